// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared definitions for the divider sequencer.
//   - Op encodings for div/divu/rem/remu.
//   - Sequencer state enum.
//   - Helpers that build the signed-MIN and all-ones constants for a given bus width.
// Ports: none (package).
// Optional feature macro used by importers: DIV_SEQ_RESULT_CACHE_EN.
package div_sequencer_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int unsigned MAX_BUS_WIDTH = 64;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    // Signed minimum (1 followed by zeros) for a w-bit bus, right-aligned in 64 bits.
    function automatic logic [MAX_BUS_WIDTH-1:0] signed_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    // All ones for a w-bit bus, right-aligned in 64 bits.
    function automatic logic [MAX_BUS_WIDTH-1:0] all_ones(input int unsigned w);
        if (w >= MAX_BUS_WIDTH) begin
            return {MAX_BUS_WIDTH{1'b1}};
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/div_special_case.sv
// div_special_case: combinational detection of divide results that need no divider.
//   - Divide by zero: div/divu -> all ones, rem/remu -> dividend.
//   - Signed overflow (MIN / -1): div -> MIN, rem -> 0. Unsigned ops never overflow.
// Ports:
//   in1, in2        dividend / divisor
//   control         op select (00 div, 01 divu, 10 rem, 11 remu)
//   is_special      result is available without the divider
//   special_result  the short-circuit result (valid when is_special)
module div_special_case
    import div_sequencer_pkg::*;
#(
    parameter int unsigned BUS_WIDTH         = 64,
    parameter int unsigned ALU_CONTROL_WIDTH = 2
) (
    input  logic [BUS_WIDTH-1:0]         in1,
    input  logic [BUS_WIDTH-1:0]         in2,
    input  logic [ALU_CONTROL_WIDTH-1:0] control,
    output logic                         is_special,
    output logic [BUS_WIDTH-1:0]         special_result
);

    localparam logic [BUS_WIDTH-1:0] SMIN = BUS_WIDTH'(signed_min(BUS_WIDTH));
    localparam logic [BUS_WIDTH-1:0] ONES = BUS_WIDTH'(all_ones(BUS_WIDTH));

    logic [1:0] op;
    logic       signed_op;
    logic       rem_op;
    logic       div_zero;
    logic       overflow;

    assign op        = control[1:0];
    assign signed_op = (op == OP_DIV) || (op == OP_REM);
    assign rem_op    = (op == OP_REM) || (op == OP_REMU);
    assign div_zero  = (in2 == '0);
    assign overflow  = signed_op && (in1 == SMIN) && (in2 == ONES);

    always_comb begin
        is_special     = div_zero || overflow;
        special_result = '0;
        if (div_zero) begin
            special_result = rem_op ? in1 : ONES;
        end else if (overflow) begin
            special_result = rem_op ? '0 : SMIN;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: sequences a fixed-latency divider for the execute stage.
//   Accepts one request at a time, holds operands on the divider inputs, counts down
//   DIV_LATENCY, captures the divider result and presents it with its tag.
//   Divide-by-zero and signed overflow complete in one cycle without the divider.
//   Optional: `define DIV_SEQ_RESULT_CACHE_EN adds a one-entry result cache that
//   replays the last normally completed op on an exact {in1, in2, control} match.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake
//   req_in1/req_in2/req_control      operands and op select
//   req_tag                          destination tag
//   flush                            kill any in-flight or held op
//   div_in1/div_in2/div_control      registered divider inputs
//   div_out                          divider result
//   resp_valid/resp_ready            response handshake
//   resp_data/resp_tag               result and its tag
//   busy                             state is not IDLE
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned BUS_WIDTH         = 64,
    parameter int unsigned ALU_CONTROL_WIDTH = 2,
    parameter int unsigned DIV_LATENCY       = 20,
    parameter int unsigned TAG_WIDTH         = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [BUS_WIDTH-1:0]         req_in1,
    input  logic [BUS_WIDTH-1:0]         req_in2,
    input  logic [ALU_CONTROL_WIDTH-1:0] req_control,
    input  logic [TAG_WIDTH-1:0]         req_tag,
    input  logic                         flush,
    output logic [BUS_WIDTH-1:0]         div_in1,
    output logic [BUS_WIDTH-1:0]         div_in2,
    output logic [ALU_CONTROL_WIDTH-1:0] div_control,
    input  logic [BUS_WIDTH-1:0]         div_out,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [BUS_WIDTH-1:0]         resp_data,
    output logic [TAG_WIDTH-1:0]         resp_tag,
    output logic                         busy
);

    localparam int unsigned CNT_W = $clog2(DIV_LATENCY + 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   accept;
    logic                   is_special;
    logic [BUS_WIDTH-1:0]   special_result;
    logic                   cache_hit;
    logic [BUS_WIDTH-1:0]   cache_result;
    logic                   complete;

    div_special_case #(
        .BUS_WIDTH         (BUS_WIDTH),
        .ALU_CONTROL_WIDTH (ALU_CONTROL_WIDTH)
    ) u_special (
        .in1            (req_in1),
        .in2            (req_in2),
        .control        (req_control),
        .is_special     (is_special),
        .special_result (special_result)
    );

    assign req_ready = (state_q == StIdle) && !flush;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != StIdle);
    // Divider result is sampled on this edge unless a flush discards it.
    assign complete  = (state_q == StBusy) && (cnt_q == CNT_W'(1)) && !flush;

`ifdef DIV_SEQ_RESULT_CACHE_EN
    logic                         cache_valid_q;
    logic [BUS_WIDTH-1:0]         cache_in1_q;
    logic [BUS_WIDTH-1:0]         cache_in2_q;
    logic [ALU_CONTROL_WIDTH-1:0] cache_ctl_q;
    logic [BUS_WIDTH-1:0]         cache_result_q;

    assign cache_hit    = cache_valid_q && (req_in1 == cache_in1_q) &&
                          (req_in2 == cache_in2_q) && (req_control == cache_ctl_q);
    assign cache_result = cache_result_q;

    // Only reset invalidates; flush leaves the last good result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid_q  <= 1'b0;
            cache_in1_q    <= '0;
            cache_in2_q    <= '0;
            cache_ctl_q    <= '0;
            cache_result_q <= '0;
        end else if (complete) begin
            cache_valid_q  <= 1'b1;
            cache_in1_q    <= div_in1;
            cache_in2_q    <= div_in2;
            cache_ctl_q    <= div_control;
            cache_result_q <= div_out;
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            div_in1     <= '0;
            div_in2     <= '0;
            div_control <= '0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            resp_tag    <= '0;
        end else if (flush) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            resp_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        resp_tag <= req_tag;
                        if (is_special) begin
                            // Divider inputs stay untouched on the short-circuit path.
                            resp_data  <= special_result;
                            resp_valid <= 1'b1;
                            state_q    <= StDone;
                        end else if (cache_hit) begin
                            resp_data  <= cache_result;
                            resp_valid <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            div_in1     <= req_in1;
                            div_in2     <= req_in2;
                            div_control <= req_control;
                            cnt_q       <= CNT_W'(DIV_LATENCY);
                            state_q     <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (complete) begin
                        resp_data  <= div_out;
                        resp_valid <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer (BUS_WIDTH=64, DIV_LATENCY=4).
// The divider is modelled as an ideal combinational function of div_in*; the sequencer is
// responsible for holding the inputs and sampling at the right time.
// Build with +define+DIV_SEQ_RESULT_CACHE_EN to exercise the result cache.
module tb_div_sequencer;

    localparam int unsigned W   = 64;
    localparam int unsigned CW  = 2;
    localparam int unsigned L   = 4;
    localparam int unsigned TW  = 5;

    localparam logic [1:0] C_DIV  = 2'b00;
    localparam logic [1:0] C_DIVU = 2'b01;
    localparam logic [1:0] C_REM  = 2'b10;
    localparam logic [1:0] C_REMU = 2'b11;

    localparam logic [63:0] SMIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] NEG7  = 64'hFFFF_FFFF_FFFF_FFF9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [W-1:0]  req_in1 = '0;
    logic [W-1:0]  req_in2 = '0;
    logic [CW-1:0] req_control = '0;
    logic [TW-1:0] req_tag = '0;
    logic          flush = 1'b0;
    logic [W-1:0]  div_in1;
    logic [W-1:0]  div_in2;
    logic [CW-1:0] div_control;
    logic [W-1:0]  div_out;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [W-1:0]  resp_data;
    logic [TW-1:0] resp_tag;
    logic          busy;

    int checks = 0;
    int failures = 0;

    div_sequencer #(
        .BUS_WIDTH         (W),
        .ALU_CONTROL_WIDTH (CW),
        .DIV_LATENCY       (L),
        .TAG_WIDTH         (TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_in1     (req_in1),
        .req_in2     (req_in2),
        .req_control (req_control),
        .req_tag     (req_tag),
        .flush       (flush),
        .div_in1     (div_in1),
        .div_in2     (div_in2),
        .div_control (div_control),
        .div_out     (div_out),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_tag    (resp_tag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] div_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [1:0] c);
        if (b == 64'd0) return 64'd0;
        case (c)
            C_DIV:   return $signed(a) / $signed(b);
            C_DIVU:  return a / b;
            C_REM:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    always_comb div_out = div_model(div_in1, div_in2, div_control);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents a request at the negedge, returns #1 after the accept edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] c,
                         input logic [4:0] t);
        @(negedge clk);
        req_in1 = a; req_in2 = b; req_control = c; req_tag = t; req_valid = 1'b1;
        chk("req_ready_at_issue", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // lat counts cycles from the accept cycle: 1 means valid right after the accept edge.
    task automatic expect_resp(input int lat, input logic [63:0] data, input logic [4:0] tag,
                               input string name);
        for (int k = 1; k < lat; k++) begin
            chk({name, "_early_valid"}, {63'd0, resp_valid}, 64'd0);
            chk({name, "_busy_ready"}, {63'd0, req_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        chk({name, "_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({name, "_data"}, resp_data, data);
        chk({name, "_tag"}, {59'd0, resp_tag}, {59'd0, tag});
    endtask

    task automatic retire(input string name);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({name, "_retired_valid"}, {63'd0, resp_valid}, 64'd0);
        chk({name, "_retired_ready"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_div_in1", div_in1, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic divide: 100 / 7 = 14
        issue(64'd100, 64'd7, C_DIV, 5'd3);
        expect_resp(L + 1, 64'd14, 5'd3, "div100_7");
        retire("div100_7");

        // rem -7 / 2 = -1 through the divider
        issue(NEG7, 64'd2, C_REM, 5'd1);
        expect_resp(L + 1, ONES, 5'd1, "rem_m7_2");
        retire("rem_m7_2");

        // Divide by zero short-circuits; divider inputs keep the previous op
        issue(64'd7, 64'd0, C_REMU, 5'd2);
        expect_resp(1, 64'd7, 5'd2, "remu_7_0");
        chk("remu_div_in1_held", div_in1, NEG7);
        chk("remu_div_in2_held", div_in2, 64'd2);
        retire("remu_7_0");
        issue(64'd5, 64'd0, C_DIVU, 5'd4);
        expect_resp(1, ONES, 5'd4, "divu_5_0");
        chk("divu_div_ctl_held", {62'd0, div_control}, {62'd0, C_REM});
        retire("divu_5_0");

        // Signed overflow
        issue(SMIN, ONES, C_DIV, 5'd5);
        expect_resp(1, SMIN, 5'd5, "div_ovf");
        retire("div_ovf");
        issue(SMIN, ONES, C_REM, 5'd6);
        expect_resp(1, 64'd0, 5'd6, "rem_ovf");
        chk("ovf_div_in1_held", div_in1, NEG7);
        retire("rem_ovf");
        // Unsigned: 2^63 / (2^64-1) truncates to 0, full latency
        issue(SMIN, ONES, C_DIVU, 5'd7);
        expect_resp(L + 1, 64'd0, 5'd7, "divu_big");
        chk("divu_big_div_in1", div_in1, SMIN);
        retire("divu_big");

        // Backpressure
        issue(64'd1000, 64'd10, C_DIVU, 5'd9);
        expect_resp(L + 1, 64'd100, 5'd9, "bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_hold_data", resp_data, 64'd100);
            chk("bp_hold_tag", {59'd0, resp_tag}, 64'd9);
            chk("bp_hold_ready", {63'd0, req_ready}, 64'd0);
        end
        retire("bp");
        issue(64'd20, 64'd4, C_DIV, 5'd10);
        expect_resp(L + 1, 64'd5, 5'd10, "after_bp");
        retire("after_bp");

        // Flush two cycles after accept, with a request presented alongside
        issue(64'd50, 64'd5, C_DIV, 5'd11);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        req_in1 = 64'd9; req_in2 = 64'd3; req_control = C_DIV; req_tag = 5'd12;
        req_valid = 1'b1;
        chk("flush_req_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_not_accepted", div_in1, 64'd50);
        for (int i = 0; i < 8; i++) begin
            chk("flush_no_resp", {63'd0, resp_valid}, 64'd0);
            @(posedge clk);
            #1;
        end
        issue(64'd9, 64'd3, C_DIV, 5'd12);
        expect_resp(L + 1, 64'd3, 5'd12, "after_flush");
        retire("after_flush");

        // Asynchronous reset mid-BUSY
        issue(64'd77, 64'd7, C_DIV, 5'd13);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, resp_valid}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_div_in1", div_in1, 64'd0);
        chk("arst_div_in2", div_in2, 64'd0);
        chk("arst_div_ctl", {62'd0, div_control}, 64'd0);
        chk("arst_resp_data", resp_data, 64'd0);
        chk("arst_resp_tag", {59'd0, resp_tag}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Repeat op: cached replay when the cache is built in
        issue(64'd100, 64'd7, C_DIV, 5'd14);
        expect_resp(L + 1, 64'd14, 5'd14, "rep_first");
        retire("rep_first");
        issue(64'd100, 64'd7, C_DIV, 5'd15);
`ifdef DIV_SEQ_RESULT_CACHE_EN
        expect_resp(1, 64'd14, 5'd15, "rep_cached");
`else
        expect_resp(L + 1, 64'd14, 5'd15, "rep_cached");
`endif
        retire("rep_cached");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(64'd100, 64'd7, C_DIV, 5'd16);
        expect_resp(L + 1, 64'd14, 5'd16, "rep_after_rst");
        retire("rep_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
